x_micro_sequencer_exec: RTL and testbench
=========================================

Name: x_micro_sequencer_exec

Overview:
Execution engine for the micro-sequencer program RAM: the reader side of the 512 x (36-bit data + 4-bit cmd) store that is filled through the i_wen/i_waddr/i_wcmd/i_wdata write port. On i_start it fetches instructions from address START_ADDR, decodes the 4-bit command and drives output words, timed waits, trigger waits, loops and jumps until HALT. It sits between the program RAM read port and the delay-line control logic that consumes o_data/o_strobe.

Parameters:
ADDR_W, 9, program RAM address width (512 entries)
DATA_W, 36, instruction data field width
CMD_W, 4, instruction command field width
START_ADDR, 0, program counter value loaded on i_start

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous, active-high reset
i_start  input  1  start program; sampled only in IDLE
i_stop  input  1  synchronous abort to IDLE; priority over everything but reset
i_trig  input  1  external event for WAITT
o_busy  output  1  high from cycle after accepted i_start until return to IDLE
o_raddr  output  ADDR_W  RAM read address (= registered pc)
i_rdata  input  DATA_W  RAM read data, valid one cycle after o_raddr
i_rcmd  input  CMD_W  RAM read cmd, valid one cycle after o_raddr
o_data  output  DATA_W  last OUT word, held until next OUT
o_strobe  output  1  one-cycle pulse when o_data updates
o_done  output  1  one-cycle pulse on HALT completion

Behaviour:
- Reset (async, i_rst=1): state IDLE, pc=START_ADDR, o_busy=0, o_data=0, o_strobe=0, o_done=0, wait_cnt=0, loop_act=0, loop_cnt=0.
- RAM read latency fixed at 1 cycle; o_raddr=pc combinationally from the pc register.
- States: IDLE, FETCH, EXEC, WAIT, WAITT.
- IDLE: i_start=1 -> pc=START_ADDR, FETCH. i_start ignored in all other states.
- FETCH: present pc; -> EXEC. Each non-waiting instruction costs exactly 2 cycles.
- EXEC decodes i_rcmd; default next pc = pc+1 mod 512 (511 wraps to 0), next state FETCH:
  0x0 NOP: no effect.
  0x1 OUT: o_data<=i_rdata, o_strobe=1 in the following cycle only.
  0x2 WAIT: N=i_rdata[31:0]; N=0 acts as NOP; else wait_cnt<=N, -> WAIT, which stays exactly N cycles then -> FETCH of pc+1.
  0x3 JUMP: pc<=i_rdata[8:0].
  0x4 LOOP: target=i_rdata[8:0], N=i_rdata[24:9]. If !loop_act: N=0 -> fall through; else loop_act=1, loop_cnt=N-1, pc<=target. If loop_act: loop_cnt=0 -> loop_act=0, fall through; else loop_cnt--, pc<=target. Body therefore executes N+1 times. Single loop level; nesting not supported.
  0x5 WAITT: -> WAITT; leave to FETCH of pc+1 on first cycle i_trig=1 (trig high in EXEC cycle not counted).
  0xF HALT: -> IDLE, o_busy=0 next cycle, o_done=1 for one cycle, loop_act cleared.
  other codes: treated as NOP.
- i_stop=1 in any non-IDLE state: -> IDLE next cycle, o_busy=0, no o_done, loop_act/wait_cnt cleared, o_data held, o_strobe forced 0.
- i_stop and i_start together in IDLE: stop wins, remain IDLE.
- o_busy registered: 1 in FETCH/EXEC/WAIT/WAITT.
- RAM writes during execution are not arbitrated here; instructions read reflect RAM content at fetch time.

Test Plan:
- Reset mid-run: assert i_rst during WAIT with N=100 -> all outputs 0, IDLE, o_raddr=0 immediately.
- Program {0:OUT 0x123456789, 1:WAIT 3, 2:OUT 0xA, 3:HALT}, pulse i_start -> o_strobe pulses 7 cycles apart (2+2+3), o_data 0x123456789 then 0xA, o_done one cycle, o_busy low after.
- Program {0:OUT 1, 1:LOOP tgt=0 N=2, 2:HALT} -> exactly 3 o_strobe pulses, then o_done.
- Program {0:WAITT, 1:OUT 5, 2:HALT}, i_trig high 10 cycles after start -> o_strobe with o_data=5 exactly 3 cycles after i_trig sampled high.
- Program {511:OUT 7, 0:HALT}, START_ADDR=511 -> pc wraps 511->0, one strobe, o_done.
- Program {0:JUMP 0} running, i_stop pulse -> IDLE next cycle, o_busy=0, no o_done; subsequent i_start restarts at pc=0.

Source files
------------

// File: rtl/x_micro_sequencer_exec.sv
// Micro-sequencer execution engine: fetches {cmd,data} from program RAM (1-cycle read) and runs OUT/WAIT/JUMP/LOOP/WAITT/HALT.
// Non-waiting instructions take 2 cycles (FETCH+EXEC); no backpressure, i_stop aborts to IDLE from any state.
module x_micro_sequencer_exec #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 36,
  parameter int CMD_W      = 4,
  parameter int START_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_trig,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [CMD_W-1:0]  i_rcmd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_strobe,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [CMD_W-1:0] CMD_OUT   = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_WAIT  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_JUMP  = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_LOOP  = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_WAITT = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_HALT  = CMD_W'(15);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_WAITT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, tgt;
  logic [31:0]       wait_cnt, wait_cnt_nxt, wait_n;
  logic              loop_act, loop_act_nxt;
  logic [15:0]       loop_cnt, loop_cnt_nxt, loop_n;
  logic [DATA_W-1:0] data_nxt;
  logic              strobe_nxt, done_nxt;

  assign o_raddr = pc;
  assign pc_inc  = pc + 1'b1;
  assign wait_n  = i_rdata[31:0];
  assign tgt     = i_rdata[ADDR_W-1:0];
  assign loop_n  = i_rdata[ADDR_W+15:ADDR_W];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      pc       <= START_PC;
      wait_cnt <= '0;
      loop_act <= 1'b0;
      loop_cnt <= '0;
      o_data   <= '0;
      o_strobe <= 1'b0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      wait_cnt <= wait_cnt_nxt;
      loop_act <= loop_act_nxt;
      loop_cnt <= loop_cnt_nxt;
      o_data   <= data_nxt;
      o_strobe <= strobe_nxt;
      o_done   <= done_nxt;
      o_busy   <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    wait_cnt_nxt = wait_cnt;
    loop_act_nxt = loop_act;
    loop_cnt_nxt = loop_cnt;
    data_nxt     = o_data;
    strobe_nxt   = 1'b0;
    done_nxt     = 1'b0;
    if (i_stop) begin
      state_nxt    = S_IDLE;
      loop_act_nxt = 1'b0;
      wait_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            pc_nxt    = START_PC;
            state_nxt = S_FETCH;
          end
        end
        S_FETCH: state_nxt = S_EXEC;
        S_EXEC: begin
          // pc advances here even for waits, so WAIT/WAITT just return to FETCH
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
          case (i_rcmd)
            CMD_OUT: begin
              data_nxt   = i_rdata;
              strobe_nxt = 1'b1;
            end
            CMD_WAIT: begin
              if (wait_n != 32'd0) begin
                wait_cnt_nxt = wait_n;
                state_nxt    = S_WAIT;
              end
            end
            CMD_JUMP: pc_nxt = tgt;
            CMD_LOOP: begin
              if (!loop_act) begin
                if (loop_n != 16'd0) begin
                  loop_act_nxt = 1'b1;
                  loop_cnt_nxt = loop_n - 16'd1;
                  pc_nxt       = tgt;
                end
              end else if (loop_cnt == 16'd0) begin
                loop_act_nxt = 1'b0;
              end else begin
                loop_cnt_nxt = loop_cnt - 16'd1;
                pc_nxt       = tgt;
              end
            end
            CMD_WAITT: state_nxt = S_WAITT;
            CMD_HALT: begin
              state_nxt    = S_IDLE;
              done_nxt     = 1'b1;
              loop_act_nxt = 1'b0;
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          if (wait_cnt == 32'd1) begin
            wait_cnt_nxt = '0;
            state_nxt    = S_FETCH;
          end else begin
            wait_cnt_nxt = wait_cnt - 32'd1;
          end
        end
        S_WAITT: if (i_trig) state_nxt = S_FETCH;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_micro_sequencer_exec.sv
// Bench for x_micro_sequencer_exec: behavioural program RAMs, directed programs, strobe/done scoreboard keyed on cycle.
module tb_x_micro_sequencer_exec;

  localparam logic [3:0] NOP = 4'h0, OUT = 4'h1, WAIT = 4'h2, JUMP = 4'h3,
                         LOOP = 4'h4, WAITT = 4'h5, HALT = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, stop = 1'b0, trig = 1'b0;
  logic        busy0, busy1, strobe0, strobe1, done0, done1;
  logic [8:0]  raddr0, raddr1;
  logic [35:0] rdata0 = '0, rdata1 = '0, data0, data1;
  logic [3:0]  rcmd0 = '0, rcmd1 = '0;
  logic [39:0] mem0 [512];
  logic [39:0] mem1 [512];

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          unit;
    bit          kind;   // 0 strobe, 1 done
    logic [35:0] data;
    int          cyc;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    {rcmd0, rdata0} <= mem0[raddr0];
    {rcmd1, rdata1} <= mem1[raddr1];
  end

  x_micro_sequencer_exec dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_stop(stop), .i_trig(trig),
    .o_busy(busy0), .o_raddr(raddr0), .i_rdata(rdata0), .i_rcmd(rcmd0),
    .o_data(data0), .o_strobe(strobe0), .o_done(done0));

  x_micro_sequencer_exec #(.START_ADDR(511)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_stop(stop), .i_trig(trig),
    .o_busy(busy1), .o_raddr(raddr1), .i_rdata(rdata1), .i_rcmd(rcmd1),
    .o_data(data1), .o_strobe(strobe1), .o_done(done1));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_ev(bit unit, bit kind, logic [35:0] d, int c);
    ev_t e;
    e.unit = unit; e.kind = kind; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(bit unit, bit kind, logic [35:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: unit %0d kind %0d at cycle %0d, expected no event", unit, kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_source", {62'd0, unit, kind}, {62'd0, e.unit, e.kind});
    if (!kind) chk("ev_data", d, e.data);
    chk("ev_cycle", cyc, e.cyc);
  endtask

  // Monitor: independent of stimulus, consumes the expectation queue
  always @(negedge clk) begin
    if (strobe0) sb_pop(1'b0, 1'b0, data0);
    if (done0)   sb_pop(1'b0, 1'b1, '0);
    if (strobe1) sb_pop(1'b1, 1'b0, data1);
    if (done1)   sb_pop(1'b1, 1'b1, '0);
  end

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
  endtask

  task automatic start_dut(bit unit, output int s);
    @(negedge clk);
    if (unit) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    s = cyc;
  endtask

  initial begin
    int s;
    clear_mem();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_data", data0, 0);
    chk("rst_strobe", strobe0, 0);
    chk("rst_done", done0, 0);
    chk("rst_raddr0", raddr0, 0);
    chk("rst_raddr1", raddr1, 511);
    rst = 1'b0;

    // OUT / WAIT 3 / OUT / HALT
    clear_mem();
    mem0[0] = {OUT, 36'h123456789};
    mem0[1] = {WAIT, 36'd3};
    mem0[2] = {OUT, 36'hA};
    mem0[3] = {HALT, 36'd0};
    start_dut(1'b0, s);
    exp_ev(0, 0, 36'h123456789, s + 2);
    exp_ev(0, 0, 36'hA, s + 9);
    exp_ev(0, 1, '0, s + 11);
    repeat (10) @(negedge clk);
    chk("prog_a_busy_before_done", busy0, 1);
    @(negedge clk);
    chk("prog_a_busy_after_done", busy0, 0);
    chk("prog_a_data_held", data0, 36'hA);
    repeat (3) @(negedge clk);

    // LOOP: body runs N+1 = 3 times
    clear_mem();
    mem0[0] = {OUT, 36'd1};
    mem0[1] = {LOOP, 36'h400};
    mem0[2] = {HALT, 36'd0};
    start_dut(1'b0, s);
    exp_ev(0, 0, 36'd1, s + 2);
    exp_ev(0, 0, 36'd1, s + 6);
    exp_ev(0, 0, 36'd1, s + 10);
    exp_ev(0, 1, '0, s + 14);
    repeat (18) @(negedge clk);

    // WAITT: trig in EXEC ignored, trig at s+10 releases
    clear_mem();
    mem0[0] = {WAITT, 36'd0};
    mem0[1] = {OUT, 36'd5};
    mem0[2] = {HALT, 36'd0};
    start_dut(1'b0, s);
    exp_ev(0, 0, 36'd5, s + 13);
    exp_ev(0, 1, '0, s + 15);
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (8) @(negedge clk);
    chk("waitt_still_busy", busy0, 1);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (8) @(negedge clk);

    // WAIT 0 as NOP, JUMP, unknown cmd as NOP
    clear_mem();
    mem0[0] = {WAIT, 36'd0};
    mem0[1] = {JUMP, 36'd5};
    mem0[2] = {OUT, 36'hBAD};
    mem0[5] = {OUT, 36'hF0F};
    mem0[6] = {4'h7, 36'h55};
    mem0[7] = {HALT, 36'd0};
    start_dut(1'b0, s);
    exp_ev(0, 0, 36'hF0F, s + 6);
    exp_ev(0, 1, '0, s + 10);
    repeat (14) @(negedge clk);

    // START_ADDR=511, pc wraps to 0
    clear_mem();
    mem1[511] = {OUT, 36'd7};
    mem1[0]   = {HALT, 36'd0};
    start_dut(1'b1, s);
    exp_ev(1, 0, 36'd7, s + 2);
    exp_ev(1, 1, '0, s + 4);
    repeat (2) @(negedge clk);
    chk("wrap_raddr", raddr1, 0);
    repeat (6) @(negedge clk);
    chk("wrap_busy_after", busy1, 0);

    // Stop an endless JUMP loop, then restart from 0
    clear_mem();
    mem0[0] = {JUMP, 36'd0};
    start_dut(1'b0, s);
    repeat (10) @(negedge clk);
    chk("stop_busy_running", busy0, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy_next", busy0, 0);
    stop = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start0 = 1'b0;
    chk("stop_beats_start", busy0, 0);
    mem0[0] = {OUT, 36'h33};
    mem0[1] = {HALT, 36'd0};
    start_dut(1'b0, s);
    exp_ev(0, 0, 36'h33, s + 2);
    exp_ev(0, 1, '0, s + 4);
    repeat (8) @(negedge clk);

    // Async reset in the middle of WAIT 100
    clear_mem();
    mem0[0] = {WAIT, 36'd100};
    mem0[1] = {OUT, 36'h99};
    start_dut(1'b0, s);
    repeat (5) @(negedge clk);
    chk("wait_raddr", raddr0, 1);
    chk("wait_busy", busy0, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_raddr", raddr0, 0);
    chk("arst_data", data0, 0);
    chk("arst_strobe", strobe0, 0);
    chk("arst_done", done0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", busy0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
